// File: rtl/edge_detect_mc.sv
// rtl/edge_detect_mc.sv - multi-channel synchronised, debounced edge detector with event counters
//
// Ports:
//   CLK      clock; every flop updates on its rising edge
//   RST      synchronous active-high reset
//   IN       asynchronous channel inputs, one bit per channel
//   MODE     detect mode for all channels: 00 rise, 01 fall, 10 both, 11 off
//   DEB_LEN  extra stable cycles required before a level change is accepted
//   CLR      synchronous clear of STICKY and CNT
//   OUT      one-cycle event pulse per channel
//   LEVEL    debounced level per channel
//   STICKY   per-channel event-seen flag
//   CNT      per-channel saturating event count, channel i at [i*CNT_W +: CNT_W]
module edge_detect_mc #(
    parameter int CH    = 4,
    parameter int SYNC  = 2,
    parameter int DEB_W = 4,
    parameter int CNT_W = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [CH-1:0]         IN,
    input  logic [1:0]            MODE,
    input  logic [DEB_W-1:0]      DEB_LEN,
    input  logic                  CLR,
    output logic [CH-1:0]         OUT,
    output logic [CH-1:0]         LEVEL,
    output logic [CH-1:0]         STICKY,
    output logic [CH*CNT_W-1:0]   CNT
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CH-1:0]       sync_q [SYNC];
    logic [CH-1:0]       sync_d [SYNC];
    logic [DEB_W-1:0]    deb_q  [CH];
    logic [DEB_W-1:0]    deb_d  [CH];
    logic [CH-1:0]       level_q, level_d;
    logic [CH-1:0]       prev_q, prev_d;
    logic [CH-1:0]       out_q, out_d;
    logic [CH-1:0]       sticky_q, sticky_d;
    logic [CH*CNT_W-1:0] cnt_q, cnt_d;

    logic [CH-1:0]       synced;
    logic [CH-1:0]       rise;
    logic [CH-1:0]       fall;
    logic [CH-1:0]       evt;

    always_comb begin
        sync_d[0] = IN;
        for (int k = 1; k < SYNC; k++) begin
            sync_d[k] = sync_q[k-1];
        end
        synced = sync_q[SYNC-1];

        // Debounce: the counter measures how long the synced input has
        // disagreed with the accepted level. ">=" rather than "==" so that
        // shrinking DEB_LEN mid-count still lets the change through.
        level_d = level_q;
        for (int i = 0; i < CH; i++) begin
            deb_d[i] = deb_q[i];
            if (synced[i] == level_q[i]) begin
                deb_d[i] = '0;
            end else if (deb_q[i] >= DEB_LEN) begin
                level_d[i] = synced[i];
                deb_d[i]   = '0;
            end else begin
                deb_d[i] = deb_q[i] + DEB_W'(1);
            end
        end

        // Events come from the registered level compared with its previous
        // value, so OUT lags LEVEL by one cycle; MODE is sampled now.
        prev_d = level_q;
        rise   = level_q & ~prev_q;
        fall   = ~level_q & prev_q;
        case (MODE)
            2'b00:   evt = rise;
            2'b01:   evt = fall;
            2'b10:   evt = rise | fall;
            default: evt = '0;
        endcase
        out_d = evt;

        // An event coincident with CLR wins: the flag is set and the count
        // restarts at one.
        sticky_d = CLR ? evt : (sticky_q | evt);
        cnt_d    = cnt_q;
        for (int i = 0; i < CH; i++) begin
            if (CLR) begin
                cnt_d[i*CNT_W +: CNT_W] = evt[i] ? CNT_W'(1) : '0;
            end else if (evt[i] && (cnt_q[i*CNT_W +: CNT_W] != CNT_MAX)) begin
                cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < SYNC; k++) begin
                sync_q[k] <= '0;
            end
            for (int i = 0; i < CH; i++) begin
                deb_q[i] <= '0;
            end
            level_q  <= '0;
            prev_q   <= '0;
            out_q    <= '0;
            sticky_q <= '0;
            cnt_q    <= '0;
        end else begin
            for (int k = 0; k < SYNC; k++) begin
                sync_q[k] <= sync_d[k];
            end
            for (int i = 0; i < CH; i++) begin
                deb_q[i] <= deb_d[i];
            end
            level_q  <= level_d;
            prev_q   <= prev_d;
            out_q    <= out_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign OUT    = out_q;
    assign LEVEL  = level_q;
    assign STICKY = sticky_q;
    assign CNT    = cnt_q;

endmodule
